// File: rtl/mvm_pkg.sv
// mvm_pkg
//   Shared types and helpers for the matrix-vector multiply output path.
//   - state_t    : serializer FSM states (IDLE, STREAM)
//   - sat_t      : saturation decision returned by sat_signed
//   - row_idx_w  : width of a row index (never below 1 bit)
//   - sat_signed : classifies a signed value against the range of a w-bit signed type
package mvm_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_HI   = 2'd1,
    SAT_LO   = 2'd2
  } sat_t;

  function automatic int row_idx_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // The caller sign-extends into 64 bits, so one function serves every lane width.
  function automatic sat_t sat_signed(input logic signed [63:0] s, input int w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    if (s > max_v) begin
      return SAT_HI;
    end else if (s < min_v) begin
      return SAT_LO;
    end
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// requant_lane
//   Combinational requantisation of one accumulator row:
//   bias add, optional ReLU, round-half-up arithmetic right shift, saturation.
//   Ports:
//     y      in  ACC_WIDTH  signed accumulator
//     bias   in  WIDTH      signed bias
//     shift  in  SHIFT_W    right-shift amount (clamped to ACC_WIDTH)
//     relu   in  1          clamp negative sums to zero
//     data   out WIDTH      saturated signed result
module requant_lane
  import mvm_pkg::*;
#(
  parameter int ACC_WIDTH = 16,
  parameter int WIDTH     = 8,
  parameter int SHIFT_W   = 4
) (
  input  logic signed [ACC_WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0]     bias,
  input  logic        [SHIFT_W-1:0]   shift,
  input  logic                        relu,
  output logic signed [WIDTH-1:0]     data
);

  // Two guard bits: one for the bias add, one for the rounding constant.
  localparam int EXT_W = ACC_WIDTH + 2;
  localparam int SH_W  = $clog2(ACC_WIDTH + 1);

  logic signed [EXT_W-1:0] sum;
  logic signed [EXT_W-1:0] rnd;
  logic signed [EXT_W-1:0] shifted;
  logic        [SH_W-1:0]  sh;
  sat_t                    sat;

  always_comb begin
    sum = {{2{y[ACC_WIDTH-1]}}, y} + {{(EXT_W-WIDTH){bias[WIDTH-1]}}, bias};
    if (relu && sum[EXT_W-1]) begin
      sum = '0;
    end

    if (32'(shift) > ACC_WIDTH) begin
      sh = SH_W'(ACC_WIDTH);
    end else begin
      sh = SH_W'(shift);
    end

    // Half-LSB bias before the floor shift gives round-half-up; zero when sh==0.
    rnd     = (sh == '0) ? '0 : (EXT_W'(1) << (sh - SH_W'(1)));
    shifted = (sum + rnd) >>> sh;

    sat = sat_signed({{(64-EXT_W){shifted[EXT_W-1]}}, shifted}, WIDTH);
    case (sat)
      SAT_HI:  data = {1'b0, {(WIDTH-1){1'b1}}};
      SAT_LO:  data = {1'b1, {(WIDTH-1){1'b0}}};
      default: data = shifted[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/mvm_requant_serializer.sv
// mvm_requant_serializer
//   Captures one result vector (ROWS accumulators) plus per-row bias and config,
//   then streams the requantised rows out in order, one per handshake.
//   Ports:
//     clk, rstn            clock, asynchronous active-low reset
//     in_valid/in_ready    vector input handshake
//     in_y, in_bias        packed vectors, row i at the i-th slice from the LSB
//     cfg_shift, cfg_relu  requant config, sampled with the vector
//     out_valid/out_ready  row output handshake
//     out_data             requantised row value
//     out_row, out_last    index of the row presented, and row==ROWS-1
//     dbg_state            current FSM state
//
//   Handshake: a transfer happens on a rising edge where valid && ready are both 1.
//   The source holds valid and its payload until that edge; the block presenting
//   out_valid keeps out_data/out_row/out_last stable while out_ready is low.
//   in_ready depends combinationally on out_ready so the next vector can be captured
//   on the edge that retires the last row, giving back-to-back vectors with no bubble.
module mvm_requant_serializer
  import mvm_pkg::*;
#(
  parameter int  ROWS      = 4,
  parameter int  ACC_WIDTH = 16,
  parameter int  WIDTH     = 8,
  parameter int  SHIFT_W   = 4,
  localparam int ROW_W     = row_idx_w(ROWS)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*ACC_WIDTH-1:0] in_y,
  input  logic [ROWS*WIDTH-1:0]     in_bias,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic                      cfg_relu,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [ROW_W-1:0]          out_row,
  output logic                      out_last,
  output state_t                    dbg_state
);

  state_t                    state_q, state_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [ROWS*ACC_WIDTH-1:0] y_q;
  logic [ROWS*WIDTH-1:0]     bias_q;
  logic [SHIFT_W-1:0]        shift_q;
  logic                      relu_q;

  logic                      capture;
  logic                      out_hs;
  logic                      row_last;
  logic signed [ACC_WIDTH-1:0] y_sel;
  logic signed [WIDTH-1:0]     bias_sel;
  logic signed [WIDTH-1:0]     lane_data;

  // Next-state and handshake decode.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    row_last  = (row_q == ROW_W'(ROWS - 1));
    out_valid = (state_q == STREAM);
    out_last  = out_valid && row_last;
    in_ready  = (state_q == IDLE) || (out_last && out_ready);
    capture   = in_valid && in_ready;
    out_hs    = out_valid && out_ready;

    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = STREAM;
          row_d   = '0;
        end
      end
      STREAM: begin
        if (out_hs) begin
          if (row_last) begin
            state_d = capture ? STREAM : IDLE;
            row_d   = '0;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        row_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Capture registers only load on an accepted vector; inputs are ignored otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_q     <= '0;
      bias_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else if (capture) begin
      y_q     <= in_y;
      bias_q  <= in_bias;
      shift_q <= cfg_shift;
      relu_q  <= cfg_relu;
    end
  end

  // Row mux from registered state only, so out_data is stable under backpressure.
  always_comb begin
    y_sel    = y_q[ACC_WIDTH-1:0];
    bias_sel = bias_q[WIDTH-1:0];
    for (int i = 0; i < ROWS; i++) begin
      if (row_q == ROW_W'(i)) begin
        y_sel    = y_q[i*ACC_WIDTH +: ACC_WIDTH];
        bias_sel = bias_q[i*WIDTH +: WIDTH];
      end
    end
  end

  requant_lane #(
    .ACC_WIDTH (ACC_WIDTH),
    .WIDTH     (WIDTH),
    .SHIFT_W   (SHIFT_W)
  ) u_lane (
    .y     (y_sel),
    .bias  (bias_sel),
    .shift (shift_q),
    .relu  (relu_q),
    .data  (lane_data)
  );

  always_comb begin
    out_data  = out_valid ? lane_data : '0;
    out_row   = row_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_mvm_requant_serializer.sv
// Testbench for mvm_requant_serializer (ROWS=4, ACC_WIDTH=16, WIDTH=8, SHIFT_W=4).
module tb_mvm_requant_serializer;

  localparam int ROWS      = 4;
  localparam int ACC_WIDTH = 16;
  localparam int WIDTH     = 8;
  localparam int SHIFT_W   = 4;
  localparam int ROW_W     = 2;
  localparam int EW        = 1 + ROW_W + WIDTH;

  logic                      clk;
  logic                      rstn;
  logic                      in_valid;
  logic                      in_ready;
  logic [ROWS*ACC_WIDTH-1:0] in_y;
  logic [ROWS*WIDTH-1:0]     in_bias;
  logic [SHIFT_W-1:0]        cfg_shift;
  logic                      cfg_relu;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [ROW_W-1:0]          out_row;
  logic                      out_last;
  mvm_pkg::state_t           dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [EW-1:0] exp_q[$];
  int            hs_cyc_q[$];
  logic [EW-1:0] mon_got;
  logic [EW-1:0] mon_exp;
  bit            rand_done;

  mvm_requant_serializer #(
    .ROWS      (ROWS),
    .ACC_WIDTH (ACC_WIDTH),
    .WIDTH     (WIDTH),
    .SHIFT_W   (SHIFT_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .in_bias   (in_bias),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  // Sampled on the falling edge: a row seen with valid && ready here transfers
  // on the following rising edge.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      mon_got = {out_last, out_row, out_data};
      hs_cyc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL row_unexpected got last=%b row=%0d data=%0d, none expected",
                 out_last, out_row, $signed(out_data));
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL row_compare got last=%b row=%0d data=%0d exp last=%b row=%0d data=%0d",
                   mon_got[EW-1], mon_got[WIDTH +: ROW_W], $signed(mon_got[WIDTH-1:0]),
                   mon_exp[EW-1], mon_exp[WIDTH +: ROW_W], $signed(mon_exp[WIDTH-1:0]));
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] model(input logic signed [ACC_WIDTH-1:0] y,
                                             input logic signed [WIDTH-1:0] b,
                                             input int sh, input bit relu);
    int s;
    s = int'(y) + int'(b);
    if (relu && s < 0) s = 0;
    if (sh > ACC_WIDTH) sh = ACC_WIDTH;
    if (sh > 0) s = (s + (1 <<< (sh - 1))) >>> sh;
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return WIDTH'(s);
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the capture edge.
  task automatic send_vector(input logic [ROWS*ACC_WIDTH-1:0] y,
                             input logic [ROWS*WIDTH-1:0] b,
                             input logic [SHIFT_W-1:0] sh,
                             input logic relu,
                             input logic [ROWS*WIDTH-1:0] exp_d,
                             output logic on_last);
    bit ok;
    ok        = 0;
    on_last   = 0;
    in_y      = y;
    in_bias   = b;
    cfg_shift = sh;
    cfg_relu  = relu;
    in_valid  = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok      = 1;
        on_last = out_last;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout in_ready=%b exp=1 within 200 cycles", in_ready);
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        exp_q.push_back({1'(r == ROWS - 1), ROW_W'(r), exp_d[r*WIDTH +: WIDTH]});
      end
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    // Scramble inputs so any use of uncaptured data shows up.
    in_y      = {$urandom, $urandom};
    in_bias   = $urandom;
    cfg_shift = SHIFT_W'($urandom_range(0, 15));
    cfg_relu  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_%s pending=%0d exp=0", name, exp_q.size());
    end
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_y      = '0;
    in_bias   = '0;
    cfg_shift = '0;
    cfg_relu  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++;
    if (out_row !== '0) begin failures++; $display("FAIL reset_out_row got=%0d exp=0", out_row); end
    checks++;
    if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    checks++;
    if (dbg_state !== mvm_pkg::IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=IDLE", dbg_state); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturate();
    logic l;
    send_vector({16'(-300), 16'(300), 16'(-50), 16'(100)}, '0, 4'd0, 1'b0,
                {8'(-128), 8'(127), 8'(-50), 8'(100)}, l);
    wait_drain("saturate");
  endtask

  task automatic test_relu();
    logic l;
    send_vector({16'(-300), 16'(300), 16'(-50), 16'(100)}, '0, 4'd0, 1'b1,
                {8'(0), 8'(127), 8'(0), 8'(100)}, l);
    wait_drain("relu");
  endtask

  task automatic test_round();
    logic l;
    send_vector({16'(0), 16'(1), 16'(-10), 16'(10)}, {8'd0, 8'd5, 8'd0, 8'd0}, 4'd2, 1'b0,
                {8'(0), 8'(2), 8'(-2), 8'(3)}, l);
    send_vector({16'(0), 16'(1), 16'(-10), 16'(10)}, {8'd0, 8'd5, 8'd0, 8'd0}, 4'd1, 1'b0,
                {8'(0), 8'(3), 8'(-5), 8'(5)}, l);
    wait_drain("round");
  endtask

  task automatic test_backpressure();
    logic l;
    hs_cyc_q.delete();
    out_ready = 1'b1;
    send_vector({16'(40), 16'(30), 16'(20), 16'(10)}, '0, 4'd0, 1'b0,
                {8'(40), 8'(30), 8'(20), 8'(10)}, l);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cycle=%0d got=%b exp=1", c, out_valid); end
      checks++;
      if (out_row !== 2'd1) begin failures++; $display("FAIL bp_out_row cycle=%0d got=%0d exp=1", c, out_row); end
      checks++;
      if (out_data !== 8'd20) begin failures++; $display("FAIL bp_out_data cycle=%0d got=%0d exp=20", c, $signed(out_data)); end
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", c, in_ready); end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_drain("backpressure");
    checks++;
    if (hs_cyc_q.size() != ROWS) begin
      failures++;
      $display("FAIL bp_row_count got=%0d exp=%0d", hs_cyc_q.size(), ROWS);
    end
  endtask

  task automatic test_back_to_back();
    logic l;
    out_ready = 1'b1;
    hs_cyc_q.delete();
    send_vector({16'(4), 16'(3), 16'(2), 16'(1)}, '0, 4'd0, 1'b0,
                {8'(4), 8'(3), 8'(2), 8'(1)}, l);
    send_vector({16'(-8), 16'(7), 16'(-6), 16'(5)}, {8'(1), 8'(1), 8'(1), 8'(1)}, 4'd0, 1'b0,
                {8'(-7), 8'(8), 8'(-5), 8'(6)}, l);
    checks++;
    if (l !== 1'b1) begin failures++; $display("FAIL b2b_accept_on_last got=%b exp=1", l); end
    wait_drain("back_to_back");
    checks++;
    if (hs_cyc_q.size() != 2 * ROWS) begin
      failures++;
      $display("FAIL b2b_row_count got=%0d exp=%0d", hs_cyc_q.size(), 2 * ROWS);
    end else if (hs_cyc_q[2*ROWS-1] - hs_cyc_q[0] != 2 * ROWS - 1) begin
      failures++;
      $display("FAIL b2b_span got=%0d exp=%0d", hs_cyc_q[2*ROWS-1] - hs_cyc_q[0], 2 * ROWS - 1);
    end
  endtask

  task automatic test_reset_mid();
    logic l;
    bit   hit;
    hit = 0;
    out_ready = 1'b1;
    send_vector({16'(9), 16'(8), 16'(7), 16'(6)}, '0, 4'd0, 1'b0,
                {8'(9), 8'(8), 8'(7), 8'(6)}, l);
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_row === 2'd2) hit = 1;
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL rmid_reach_row2 got=%0d exp=2", out_row); end
    rstn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_row !== '0) begin failures++; $display("FAIL rmid_out_row got=%0d exp=0", out_row); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
    send_vector({16'(-1), 16'(-2), 16'(-3), 16'(-4)}, '0, 4'd0, 1'b0,
                {8'(-1), 8'(-2), 8'(-3), 8'(-4)}, l);
    checks++;
    if (out_row !== '0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rmid_restart got valid=%b row=%0d exp valid=1 row=0", out_valid, out_row);
    end
    wait_drain("reset_mid");
  endtask

  task automatic test_random();
    rand_done = 0;
    fork
      begin
        logic [ROWS*ACC_WIDTH-1:0] yv;
        logic [ROWS*WIDTH-1:0]     bv;
        logic [ROWS*WIDTH-1:0]     ev;
        logic [SHIFT_W-1:0]        sh;
        logic                      rl;
        logic                      l;
        for (int v = 0; v < 16; v++) begin
          for (int r = 0; r < ROWS; r++) begin
            yv[r*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'($urandom_range(0, 65535));
            bv[r*WIDTH +: WIDTH]         = WIDTH'($urandom_range(0, 255));
          end
          sh = SHIFT_W'($urandom_range(0, 15));
          rl = 1'($urandom_range(0, 1));
          for (int r = 0; r < ROWS; r++) begin
            ev[r*WIDTH +: WIDTH] = model(yv[r*ACC_WIDTH +: ACC_WIDTH], bv[r*WIDTH +: WIDTH],
                                         int'(sh), rl);
          end
          send_vector(yv, bv, sh, rl, ev, l);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("random");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_saturate();
    test_relu();
    test_round();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
